counter_enb_sequencer: RTL and testbench

//   Upstream control stage for the 8-bit enabled counter. Generates the count_enb

---
 rtl/counter_ctrl_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 43 ++++
 rtl/counter_enb_sequencer.sv | 138 +++++++++++++
 tb/tb_counter_enb_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter control stages: state encoding and default widths.
package counter_ctrl_pkg;

    localparam int DIV_W_DEF   = 8;
    localparam int BURST_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    // True when the sequencer is doing timed work and the prescaler must run.
    function automatic logic is_active(input state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..div while enabled and flags the terminal count.
// Held at zero while disabled, so every enable starts a fresh period.
module tick_prescaler
    import counter_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] pre_cnt_r;
    logic [DIV_W-1:0] pre_cnt_nxt_s;
    logic             term_s;

    assign term_s = (pre_cnt_r == div);
    assign tick   = en && term_s;

    // Next prescale count: wrap at the divider value, clear when idle.
    always_comb begin
        pre_cnt_nxt_s = '0;
        if (!en) begin
            pre_cnt_nxt_s = '0;
        end else if (term_s) begin
            pre_cnt_nxt_s = '0;
        end else begin
            pre_cnt_nxt_s = pre_cnt_r + DIV_W'(1);
        end
    end

    // Prescale count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_nxt_s;
        end
    end

endmodule

// File: rtl/counter_enb_sequencer.sv
// Command sequencer producing the registered count_enb strobe for the 8-bit counter.
// Supports continuous run, single step and N-pulse bursts at a programmable rate.
module counter_enb_sequencer
    import counter_ctrl_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               burst,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DIV_W-1:0]   prescale_div,
    output logic               count_enb,
    output logic               busy,
    output logic               done
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [DIV_W-1:0]   div_q_r;
    logic [DIV_W-1:0]   div_q_nxt_s;
    logic [BURST_W-1:0] rem_r;
    logic [BURST_W-1:0] rem_nxt_s;
    logic               count_enb_r;
    logic               count_enb_nxt_s;
    logic               done_r;
    logic               done_nxt_s;
    logic               busy_r;
    logic               zero_done_r;
    logic               zero_done_nxt_s;
    logic               tick_s;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (is_active(state_r)),
        .div   (div_q_r),
        .tick  (tick_s)
    );

    // Next-state, remaining-pulse and output decode; stop always beats a pending tick.
    always_comb begin
        state_nxt_s     = state_r;
        div_q_nxt_s     = div_q_r;
        rem_nxt_s       = rem_r;
        count_enb_nxt_s = 1'b0;
        done_nxt_s      = 1'b0;
        zero_done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A zero-length burst completes one cycle after it was accepted.
                done_nxt_s = zero_done_r && !stop;
                if (stop) begin
                    rem_nxt_s = '0;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                    div_q_nxt_s = prescale_div;
                    rem_nxt_s   = '0;
                end else if (burst) begin
                    div_q_nxt_s = prescale_div;
                    if (burst_len == BURST_W'(0)) begin
                        zero_done_nxt_s = 1'b1;
                        rem_nxt_s       = '0;
                    end else begin
                        state_nxt_s = ST_BURST;
                        rem_nxt_s   = burst_len;
                    end
                end else if (step) begin
                    state_nxt_s = ST_BURST;
                    div_q_nxt_s = prescale_div;
                    rem_nxt_s   = BURST_W'(1);
                end else begin
                    rem_nxt_s = rem_r;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    count_enb_nxt_s = tick_s;
                end
            end
            ST_BURST: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                    rem_nxt_s   = '0;
                end else if (tick_s) begin
                    count_enb_nxt_s = 1'b1;
                    if (rem_r == BURST_W'(1)) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                        rem_nxt_s   = '0;
                    end else begin
                        rem_nxt_s = rem_r - BURST_W'(1);
                    end
                end else begin
                    rem_nxt_s = rem_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                rem_nxt_s   = '0;
            end
        endcase
    end

    // State, sampled command parameters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            div_q_r     <= '0;
            rem_r       <= '0;
            count_enb_r <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            zero_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            div_q_r     <= div_q_nxt_s;
            rem_r       <= rem_nxt_s;
            count_enb_r <= count_enb_nxt_s;
            done_r      <= done_nxt_s;
            busy_r      <= is_active(state_nxt_s);
            zero_done_r <= zero_done_nxt_s;
        end
    end

    assign count_enb = count_enb_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_counter_enb_sequencer.sv
// Directed bench for counter_enb_sequencer with a model of the downstream 8-bit counter.
module tb_counter_enb_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       step;
    logic       burst;
    logic [7:0] burst_len;
    logic [7:0] prescale_div;
    logic       count_enb;
    logic       busy;
    logic       done;

    logic [7:0]  down_cnt;
    int          checks;
    int          errors;
    logic [23:0] obs_enb;
    logic [23:0] obs_done;
    int          pulses;
    int          dones;
    int          busies;
    logic        found;

    counter_enb_sequencer #(
        .DIV_W   (8),
        .BURST_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .step         (step),
        .burst        (burst),
        .burst_len    (burst_len),
        .prescale_div (prescale_div),
        .count_enb    (count_enb),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream enabled counter fed by count_enb.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            down_cnt <= 8'd0;
        end else if (count_enb) begin
            down_cnt <= down_cnt + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
        burst = 1'b0;
        burst_len    = 8'd0;
        prescale_div = 8'd0;

        // 1: reset held for 5 cycles, then released
        repeat (5) cyc();
        chk("t1_enb_in_reset", 32'(count_enb), 32'd0);
        chk("t1_busy_in_reset", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (3) cyc();
        chk("t1_enb", 32'(count_enb), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_done", 32'(done), 32'd0);
        chk("t1_down_cnt", 32'(down_cnt), 32'd0);

        // 2: continuous run at div=0, stopped after 20 enabled cycles
        prescale_div = 8'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t2_busy_accept", 32'(busy), 32'd1);
        chk("t2_enb_accept", 32'(count_enb), 32'd0);
        cyc();
        chk("t2_enb_first", 32'(count_enb), 32'd1);
        repeat (19) cyc();
        chk("t2_enb_20th", 32'(count_enb), 32'd1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t2_enb_after_stop", 32'(count_enb), 32'd0);
        chk("t2_busy_after_stop", 32'(busy), 32'd0);
        chk("t2_done_after_stop", 32'(done), 32'd0);
        chk("t2_down_cnt", 32'(down_cnt), 32'd20);

        // 3: burst of 5 at div=3; parameter changes while busy must be ignored
        prescale_div = 8'd3;
        burst_len    = 8'd5;
        burst = 1'b1;
        cyc();
        burst = 1'b0;
        prescale_div = 8'd0;
        burst_len    = 8'd1;
        chk("t3_busy_accept", 32'(busy), 32'd1);
        obs_enb  = 24'd0;
        obs_done = 24'd0;
        for (int k = 0; k < 24; k++) begin
            cyc();
            obs_enb[k]  = count_enb;
            obs_done[k] = done;
            if (k == 18) chk("t3_busy_before_last", 32'(busy), 32'd1);
            if (k == 20) chk("t3_busy_after_done", 32'(busy), 32'd0);
        end
        chk("t3_enb_pattern", 32'(obs_enb), 32'h0008_8888);
        chk("t3_done_pattern", 32'(obs_done), 32'h0008_0000);
        chk("t3_down_cnt", 32'(down_cnt), 32'd25);

        // 4: single step at div=0, then zero-length burst
        prescale_div = 8'd0;
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        chk("t4_step_enb", 32'(count_enb), 32'd1);
        chk("t4_step_done", 32'(done), 32'd1);
        cyc();
        chk("t4_step_enb_after", 32'(count_enb), 32'd0);
        chk("t4_step_done_after", 32'(done), 32'd0);
        chk("t4_step_busy_after", 32'(busy), 32'd0);
        burst_len = 8'd0;
        burst = 1'b1;
        cyc();
        burst = 1'b0;
        chk("t4_zero_busy_accept", 32'(busy), 32'd0);
        chk("t4_zero_done_accept", 32'(done), 32'd0);
        cyc();
        chk("t4_zero_done", 32'(done), 32'd1);
        chk("t4_zero_enb", 32'(count_enb), 32'd0);
        chk("t4_zero_busy", 32'(busy), 32'd0);
        cyc();
        chk("t4_zero_done_after", 32'(done), 32'd0);
        chk("t4_down_cnt", 32'(down_cnt), 32'd26);

        // 5: burst of 10 at div=1 aborted by stop after the third pulse
        prescale_div = 8'd1;
        burst_len    = 8'd10;
        burst = 1'b1;
        cyc();
        burst = 1'b0;
        pulses = 0;
        found  = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cyc();
            if (count_enb) pulses++;
            if (pulses == 3) found = 1'b1;
        end
        chk("t5_third_pulse_seen", 32'(found), 32'd1);
        stop  = 1'b1;
        start = 1'b1;
        cyc();
        stop  = 1'b0;
        start = 1'b0;
        chk("t5_busy_after_stop", 32'(busy), 32'd0);
        chk("t5_enb_after_stop", 32'(count_enb), 32'd0);
        chk("t5_done_after_stop", 32'(done), 32'd0);
        pulses = 0;
        dones  = 0;
        busies = 0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            pulses += int'(count_enb);
            dones  += int'(done);
            busies += int'(busy);
        end
        chk("t5_no_more_pulses", 32'(pulses), 32'd0);
        chk("t5_no_done", 32'(dones), 32'd0);
        chk("t5_start_ignored", 32'(busies), 32'd0);

        // 6: commands while busy are ignored; async reset clears outputs without a clock
        prescale_div = 8'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        start = 1'b1;
        step  = 1'b1;
        cyc();
        start = 1'b0;
        step  = 1'b0;
        cyc();
        chk("t6_busy_cmd_ignored", 32'(busy), 32'd1);
        chk("t6_no_step_done", 32'(done), 32'd0);
        chk("t6_run_enb", 32'(count_enb), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_enb", 32'(count_enb), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_done", 32'(done), 32'd0);
        #10;
        reset = 1'b1;
        busies = 0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            busies += int'(busy);
            pulses += int'(count_enb);
        end
        chk("t6_idle_after_reset_busy", 32'(busies), 32'd0);
        chk("t6_idle_after_reset_enb", 32'(pulses), 32'd0);
        prescale_div = 8'd2;
        start = 1'b1;
        step  = 1'b1;
        cyc();
        start = 1'b0;
        step  = 1'b0;
        obs_enb  = 24'd0;
        obs_done = 24'd0;
        for (int k = 0; k < 9; k++) begin
            cyc();
            obs_enb[k]  = count_enb;
            obs_done[k] = done;
        end
        chk("t6_start_wins_enb", 32'(obs_enb), 32'h0000_0124);
        chk("t6_start_wins_done", 32'(obs_done), 32'd0);
        chk("t6_start_wins_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t6_final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
